// File: rtl/pipe_skid_reg.sv
// Parametrised pipeline stage register with a valid/ready handshake, an optional
// 2-entry skid buffer, synchronous flush to a bubble payload and a stall counter.
module pipe_skid_reg #(
  parameter int unsigned       DATA_W    = 65,
  parameter logic [DATA_W-1:0] FLUSH_VAL = '0,
  parameter bit                SKID_EN   = 1'b1,
  parameter int unsigned       CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  input  logic              clr_cnt,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [1:0]        occupancy
);

  // bit0 = main entry valid, bit1 = skid entry valid
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b01,
    FULL  = 2'b11
  } state_t;

  state_t            state_q, state_d;
  logic              ready_q, ready_d;
  logic              accept, pop;
  logic              load_main_in, load_main_skid, load_skid;
  logic [DATA_W-1:0] main_q, skid_q;

  assign out_valid = (state_q != EMPTY);
  assign in_ready  = SKID_EN ? ready_q : (!out_valid || out_ready);
  assign accept    = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign out_data  = out_valid ? main_q : FLUSH_VAL;

  always_comb begin
    state_d        = state_q;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (accept) begin
            load_main_in = 1'b1;
            state_d      = ONE;
          end
        end
        ONE: begin
          // Without a skid entry an accept always coincides with a pop,
          // so FULL stays unreachable.
          if (accept && (pop || !SKID_EN)) begin
            load_main_in = 1'b1;
          end else if (accept) begin
            load_skid = 1'b1;
            state_d   = FULL;
          end else if (pop) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (pop) begin
            load_main_skid = 1'b1;
            state_d        = ONE;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
    ready_d = (state_d != FULL);
  end

  always_comb begin
    occupancy = 2'd0;
    case (state_q)
      ONE:     occupancy = 2'd1;
      FULL:    occupancy = 2'd2;
      default: occupancy = 2'd0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      ready_q <= ready_d;
    end
  end

  // Payload storage needs no reset; validity lives in state_q.
  always_ff @(posedge clk) begin
    if (load_main_in) begin
      main_q <= in_data;
    end else if (load_main_skid) begin
      main_q <= skid_q;
    end
    if (load_skid) begin
      skid_q <= in_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (clr_cnt) begin
      stall_cnt <= '0;
    end else if (out_valid && !out_ready && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Drives a skid-buffered and a pass-through instance with shared stimulus and
// compares both against queue-based reference models every cycle.
module tb_pipe_skid_reg;

  localparam int unsigned       DW   = 65;
  localparam int unsigned       CW   = 4;
  localparam int                CMAX = 15;
  localparam logic [DW-1:0]     FV   = 65'h1_0000_0000_0000_0013;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0, clr_cnt = 1'b0;
  logic [DW-1:0] in_data = '0;

  logic          s_in_ready, s_out_valid, p_in_ready, p_out_valid;
  logic [DW-1:0] s_out_data, p_out_data;
  logic [CW-1:0] s_cnt, p_cnt;
  logic [1:0]    s_occ, p_occ;

  int errors = 0;
  int checks = 0;

  logic [DW-1:0] q_s[$];
  logic [DW-1:0] q_p[$];
  int cnt_s = 0;
  int cnt_p = 0;

  always #5 clk = ~clk;

  pipe_skid_reg #(.DATA_W(DW), .FLUSH_VAL(FV), .SKID_EN(1'b1), .CNT_W(CW)) dut_skid (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(s_in_ready), .in_data(in_data),
    .out_valid(s_out_valid), .out_ready(out_ready), .out_data(s_out_data),
    .clr_cnt(clr_cnt), .stall_cnt(s_cnt), .occupancy(s_occ)
  );

  pipe_skid_reg #(.DATA_W(DW), .FLUSH_VAL(FV), .SKID_EN(1'b0), .CNT_W(CW)) dut_pass (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(p_in_ready), .in_data(in_data),
    .out_valid(p_out_valid), .out_ready(out_ready), .out_data(p_out_data),
    .clr_cnt(clr_cnt), .stall_cnt(p_cnt), .occupancy(p_occ)
  );

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_outputs();
    logic rdy_p;
    rdy_p = (q_p.size() == 0) || out_ready;
    check("s_in_ready",  DW'(s_in_ready),  DW'(q_s.size() < 2));
    check("s_out_valid", DW'(s_out_valid), DW'(q_s.size() != 0));
    check("s_out_data",  s_out_data,       (q_s.size() != 0) ? q_s[0] : FV);
    check("s_occupancy", DW'(s_occ),       DW'(q_s.size()));
    check("s_stall_cnt", DW'(s_cnt),       DW'(cnt_s));
    check("p_in_ready",  DW'(p_in_ready),  DW'(rdy_p));
    check("p_out_valid", DW'(p_out_valid), DW'(q_p.size() != 0));
    check("p_out_data",  p_out_data,       (q_p.size() != 0) ? q_p[0] : FV);
    check("p_occupancy", DW'(p_occ),       DW'(q_p.size()));
    check("p_stall_cnt", DW'(p_cnt),       DW'(cnt_p));
  endtask

  // One clock cycle: apply inputs, check at the falling edge, advance models after the rising edge.
  task automatic step(input logic iv, input logic [DW-1:0] d, input logic ordy,
                      input logic fl, input logic clr);
    logic acc_s, pop_s, stl_s, acc_p, pop_p, stl_p;
    in_valid = iv; in_data = d; out_ready = ordy; flush = fl; clr_cnt = clr;
    @(negedge clk);
    check_outputs();
    acc_s = iv && (q_s.size() < 2);
    pop_s = (q_s.size() != 0) && ordy;
    stl_s = (q_s.size() != 0) && !ordy;
    acc_p = iv && ((q_p.size() == 0) || ordy);
    pop_p = (q_p.size() != 0) && ordy;
    stl_p = (q_p.size() != 0) && !ordy;
    @(posedge clk);
    #1;
    if (clr) cnt_s = 0; else if (stl_s && cnt_s < CMAX) cnt_s++;
    if (clr) cnt_p = 0; else if (stl_p && cnt_p < CMAX) cnt_p++;
    if (fl) begin
      q_s.delete();
      q_p.delete();
    end else begin
      if (pop_s) void'(q_s.pop_front());
      if (acc_s) q_s.push_back(d);
      if (pop_p) void'(q_p.pop_front());
      if (acc_p) q_p.push_back(d);
    end
  endtask

  // Asserts reset between clock edges and checks outputs before any edge arrives.
  task automatic async_reset();
    #2;
    rst_n = 1'b0;
    in_valid = 1'b0; flush = 1'b0; clr_cnt = 1'b0; out_ready = 1'b0;
    #1;
    check("rst_s_out_valid", DW'(s_out_valid), '0);
    check("rst_s_out_data",  s_out_data,       FV);
    check("rst_s_in_ready",  DW'(s_in_ready),  DW'(1));
    check("rst_s_occupancy", DW'(s_occ),       '0);
    check("rst_s_stall_cnt", DW'(s_cnt),       '0);
    check("rst_p_out_valid", DW'(p_out_valid), '0);
    check("rst_p_out_data",  p_out_data,       FV);
    check("rst_p_occupancy", DW'(p_occ),       '0);
    q_s.delete();
    q_p.delete();
    cnt_s = 0;
    cnt_p = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [DW-1:0] rd;
    async_reset();

    // Stream three words back to back, then reset while a word is still held.
    step(1'b1, 65'h1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 65'h2, 1'b1, 1'b0, 1'b0);
    step(1'b1, 65'h3, 1'b1, 1'b0, 1'b0);
    check("stream_valid", DW'(s_out_valid), DW'(1));
    async_reset();

    // Backpressure fill then drain.
    step(1'b1, 65'hA, 1'b0, 1'b0, 1'b0);
    step(1'b1, 65'hB, 1'b0, 1'b0, 1'b0);
    check("full_occ", DW'(s_occ), DW'(2));
    step(1'b1, 65'hD, 1'b0, 1'b0, 1'b0);
    step(1'b0, 65'h0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 65'h0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 65'h0, 1'b1, 1'b0, 1'b0);

    // Flush while full drops both entries and the presented word.
    step(1'b1, 65'hA, 1'b0, 1'b0, 1'b0);
    step(1'b1, 65'hB, 1'b0, 1'b0, 1'b0);
    step(1'b1, 65'hC, 1'b0, 1'b1, 1'b0);
    check("flush_occ", DW'(s_occ), '0);
    step(1'b0, 65'h0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 65'h0, 1'b1, 1'b0, 1'b0);

    // Pass-through stall and same-cycle replacement.
    step(1'b1, 65'h5, 1'b0, 1'b0, 1'b0);
    step(1'b1, 65'h9, 1'b0, 1'b0, 1'b0);
    step(1'b1, 65'h6, 1'b1, 1'b1, 1'b0);
    step(1'b1, 65'h5, 1'b0, 1'b0, 1'b0);
    step(1'b1, 65'h6, 1'b1, 1'b0, 1'b0);
    check("pass_replace", p_out_data, 65'h6);

    // Stall counter saturation, clear while stalled, then resume.
    step(1'b0, 65'h0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 20; i++) step(1'b0, 65'h0, 1'b0, 1'b0, 1'b0);
    check("stall_sat", DW'(s_cnt), DW'(CMAX));
    step(1'b0, 65'h0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 65'h0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 65'h0, 1'b0, 1'b0, 1'b0);

    // Randomized traffic with occasional flush, clear and reset.
    for (int i = 0; i < 800; i++) begin
      rd = {1'($urandom()), $urandom(), $urandom()};
      step(1'($urandom_range(99, 0) < 65), rd, 1'($urandom_range(99, 0) < 55),
           1'($urandom_range(99, 0) < 4), 1'($urandom_range(99, 0) < 3));
      if ($urandom_range(199, 0) == 0) async_reset();
    end
    step(1'b0, 65'h0, 1'b1, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
